// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronised lock gates a programmable delay, then releases N_RST resets one gap apart.
// Async inputs take SYNC_STAGES cycles to be visible; every output is registered, adding one more cycle.
module rst_seq_gen #(
  parameter int N_RST       = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 3,
  parameter int GAP_CYCLES  = 16,
  parameter int MIN_ASSERT  = 16
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Locked_SI,
  input  logic [N_RST-1:0] RstReq_RBI,
  input  logic             SwRst_SI,
  input  logic [CNT_W-1:0] Delay_DI,
  input  logic             ClkEn_SI,
  output logic [N_RST-1:0] Rst_RBO,
  output logic             ClkEn_SO,
  output logic             Busy_SO,
  output logic [2:0]       State_SO
);

  localparam int IDX_W = (N_RST > 1) ? $clog2(N_RST) : 1;
  localparam int STR_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_RST - 1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    DELAY     = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [N_RST-1:0]                  en_q, en_d;
  logic [N_RST-1:0][STR_W-1:0]       str_q, str_d;
  logic [N_RST-1:0]                  rst_q, rst_d;
  logic                              clken_q, clken_d;
  logic [SYNC_STAGES-1:0]            lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0]            clken_sync_q, clken_sync_d;
  logic [SYNC_STAGES-1:0][N_RST-1:0] req_sync_q, req_sync_d;
  logic [N_RST-1:0]                  rel_vec;
  logic                              lock_s, clken_s, fault;
  logic [N_RST-1:0]                  req_s;

  always_comb begin
    lock_sync_d  = {lock_sync_q[SYNC_STAGES-2:0], Locked_SI};
    clken_sync_d = {clken_sync_q[SYNC_STAGES-2:0], ClkEn_SI};
    req_sync_d   = {req_sync_q[SYNC_STAGES-2:0], RstReq_RBI};
    lock_s       = lock_sync_q[SYNC_STAGES-1];
    clken_s      = clken_sync_q[SYNC_STAGES-1];
    req_s        = req_sync_q[SYNC_STAGES-1];
  end

  // WAIT_LOCK simply waits for lock; only the later states treat a missing lock as a fault.
  assign fault = SwRst_SI || (!lock_s && (state_q inside {DELAY, RELEASE, RUN}));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_vec = '0;
    case (state_q)
      HOLD: begin
        if (cnt_q == '0) state_d = WAIT_LOCK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = DELAY;
          cnt_d   = Delay_DI;
        end
      end
      DELAY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = GAP_LOAD;
          rel_vec = N_RST'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (idx_q == IDX_LAST) begin
          state_d = RUN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = GAP_LOAD;
          rel_vec = N_RST'(1) << idx_d;
        end
      end
      RUN: ;
      default: begin
        state_d = HOLD;
        cnt_d   = HOLD_LOAD;
      end
    endcase
    if (fault) begin
      state_d = HOLD;
      cnt_d   = HOLD_LOAD;
      idx_d   = '0;
    end
  end

  // A channel is scheduled once en is set; it stays low until its request has been quiet for SYNC_STAGES cycles.
  always_comb begin
    str_d   = str_q;
    rst_d   = '0;
    en_d    = (state_d == RELEASE || state_d == RUN) ? (en_q | rel_vec) : '0;
    clken_d = (state_q == RUN) && !fault && clken_s;
    for (int i = 0; i < N_RST; i++) begin
      if (!req_s[i])            str_d[i] = STR_W'(SYNC_STAGES);
      else if (str_q[i] != '0)  str_d[i] = str_q[i] - STR_W'(1);
      rst_d[i] = en_d[i] && req_s[i] && (str_q[i] <= STR_W'(1));
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q      <= HOLD;
      cnt_q        <= HOLD_LOAD;
      idx_q        <= '0;
      en_q         <= '0;
      str_q        <= '0;
      rst_q        <= '0;
      clken_q      <= 1'b0;
      lock_sync_q  <= '0;
      clken_sync_q <= '0;
      req_sync_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      en_q         <= en_d;
      str_q        <= str_d;
      rst_q        <= rst_d;
      clken_q      <= clken_d;
      lock_sync_q  <= lock_sync_d;
      clken_sync_q <= clken_sync_d;
      req_sync_q   <= req_sync_d;
    end
  end

  assign Rst_RBO  = rst_q;
  assign ClkEn_SO = clken_q;
  assign Busy_SO  = (state_q != RUN);
  assign State_SO = state_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: timestamp-based reference model feeds a per-cycle expectation queue.
module tb_rst_seq_gen;
  localparam int N = 4, CW = 16, S = 3, GAP = 16, MINA = 16, MAXC = 16384;

  logic          Clk_CI = 1'b0;
  logic          Rst_RBI = 1'b0;
  logic          Locked_SI = 1'b1;
  logic [N-1:0]  RstReq_RBI = '1;
  logic          SwRst_SI = 1'b0;
  logic [CW-1:0] Delay_DI = 16'd320;
  logic          ClkEn_SI = 1'b1;
  logic [N-1:0]  Rst_RBO;
  logic          ClkEn_SO;
  logic          Busy_SO;
  logic [2:0]    State_SO;

  rst_seq_gen dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Locked_SI(Locked_SI), .RstReq_RBI(RstReq_RBI),
    .SwRst_SI(SwRst_SI), .Delay_DI(Delay_DI), .ClkEn_SI(ClkEn_SI), .Rst_RBO(Rst_RBO),
    .ClkEn_SO(ClkEn_SO), .Busy_SO(Busy_SO), .State_SO(State_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    int           cyc;
    logic [2:0]   st;
    logic [N-1:0] rst;
    logic         ce;
    logic         busy;
  } exp_t;

  exp_t q[$];
  int   t = 0, r0 = 0, hs = 0, wx = -1, dl = 0;
  int   vec_cnt = 0, err_cnt = 0;
  bit   mon_en = 1'b0;

  bit           lock_h [MAXC];
  bit           ce_h   [MAXC];
  bit           sw_h   [MAXC];
  logic [N-1:0] req_h  [MAXC];
  int           dly_h  [MAXC];

  // Synchronised view of an input in cycle u: what was driven S cycles earlier, zero before reset release.
  function automatic bit lock_vis(int u);
    return (u - S >= r0) ? lock_h[u-S] : 1'b0;
  endfunction
  function automatic bit ce_vis(int u);
    return (u - S >= r0) ? ce_h[u-S] : 1'b0;
  endfunction
  function automatic bit req_vis(int k, int u);
    return (u - S >= r0) ? req_h[u-S][k] : 1'b0;
  endfunction

  function automatic int rel_start();
    return wx + ((dl == 0) ? 1 : dl) + 1;
  endfunction

  // Phase of the sequence in cycle u, from when HOLD began and when lock was seen.
  function automatic int st_at(int u);
    if (u < hs + MINA)           return 0;
    if (wx < 0 || u <= wx)       return 1;
    if (u < rel_start())         return 2;
    if (u < rel_start() + N*GAP) return 3;
    return 4;
  endfunction

  function automatic void model_cycle(int c);
    exp_t e;
    int   st;
    bit   flt, ok;
    st = st_at(c);
    if (st == 1 && wx < 0 && lock_vis(c)) begin
      wx = c;
      dl = dly_h[c];
    end
    flt = sw_h[c] || (!lock_vis(c) && st >= 2);
    if (flt) begin
      hs = c + 1;
      wx = -1;
    end
    e.cyc  = c + 1;
    e.st   = 3'(st_at(c + 1));
    e.busy = (e.st != 3'd4);
    e.ce   = (st == 4) && !flt && ce_vis(c);
    for (int k = 0; k < N; k++) begin
      ok = (e.st >= 3'd3) && (c + 1 >= rel_start() + k*GAP);
      for (int j = 1; j <= S; j++)
        if (!req_vis(k, c + 1 - j)) ok = 1'b0;
      e.rst[k] = ok;
    end
    q.push_back(e);
  endfunction

  task automatic cmp(string name, int c, logic [31:0] got, logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, want);
    end
  endtask

  always @(negedge Clk_CI) begin
    if (mon_en) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc < t) begin
        e = q.pop_front();
        cmp("stale_expectation", e.cyc, 32'(t), 32'(e.cyc));
      end
      if (q.size() > 0 && q[0].cyc == t) begin
        e = q.pop_front();
        cmp("Rst_RBO",  t, 32'(Rst_RBO),  32'(e.rst));
        cmp("ClkEn_SO", t, 32'(ClkEn_SO), 32'(e.ce));
        cmp("Busy_SO",  t, 32'(Busy_SO),  32'(e.busy));
        cmp("State_SO", t, 32'(State_SO), 32'(e.st));
      end else begin
        cmp("missing_expectation", t, 32'(q.size()), 32'(1));
      end
    end
  end

  task automatic step();
    if (t >= MAXC - 2) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", t, MAXC);
      $fatal(1, "history exhausted");
    end
    lock_h[t] = Locked_SI;
    ce_h[t]   = ClkEn_SI;
    sw_h[t]   = SwRst_SI;
    req_h[t]  = RstReq_RBI;
    dly_h[t]  = int'(Delay_DI);
    model_cycle(t);
    @(posedge Clk_CI);
    #1;
    t++;
    SwRst_SI = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_state(int s, int budget);
    for (int i = 0; i < budget && st_at(t) != s; i++) step();
    cmp("reach_state", t, 32'(st_at(t)), 32'(s));
  endtask

  task automatic do_reset();
    exp_t e;
    mon_en  = 1'b0;
    Rst_RBI = 1'b0;
    q.delete();
    repeat (2) begin
      @(posedge Clk_CI);
      t++;
    end
    #1;
    Rst_RBI = 1'b1;
    r0 = t; hs = t; wx = -1; dl = 0;
    e.cyc = t; e.st = 3'd0; e.rst = '0; e.ce = 1'b0; e.busy = 1'b1;
    q.push_back(e);
    mon_en = 1'b1;
  endtask

  initial begin
    // Power-up ordering with a long lock delay.
    do_reset();
    run_until_state(4, 600);
    run(20);

    // Short per-channel request while running.
    RstReq_RBI[2] = 1'b0;
    run(5);
    RstReq_RBI = '1;
    run(20);

    // Software reset together with a clock-enable change, then a second pulse inside HOLD.
    Delay_DI = 16'd12;
    SwRst_SI = 1'b1;
    ClkEn_SI = 1'b0;
    step();
    run(5);
    SwRst_SI = 1'b1;
    step();
    ClkEn_SI = 1'b1;
    run_until_state(4, 300);
    run(5);

    // Lock loss after channel 1 has been released.
    Delay_DI = 16'd20;
    SwRst_SI = 1'b1;
    step();
    for (int i = 0; i < 1000 && !(st_at(t) == 3 && t >= rel_start() + GAP + 1); i++) step();
    cmp("reach_release_ch1", t, 32'(st_at(t)), 32'(3));
    Locked_SI = 1'b0;
    run(8);
    Locked_SI = 1'b1;
    run_until_state(4, 400);
    run(5);

    // Zero lock delay.
    Delay_DI = 16'd0;
    SwRst_SI = 1'b1;
    step();
    run_until_state(4, 300);
    run(5);

    // Random mix of lock drops, software resets, channel requests and enable toggles.
    for (int i = 0; i < 2500; i++) begin
      if (Locked_SI) begin
        if ($urandom_range(0, 399) == 0) Locked_SI = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        Locked_SI = 1'b1;
      end
      SwRst_SI = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < N; k++) begin
        if (RstReq_RBI[k]) begin
          if ($urandom_range(0, 79) == 0) RstReq_RBI[k] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          RstReq_RBI[k] = 1'b1;
        end
      end
      if ($urandom_range(0, 39) == 0) ClkEn_SI = ~ClkEn_SI;
      Delay_DI = 16'($urandom_range(0, 40));
      step();
    end

    // Asynchronous reset while running: outputs clear before any clock edge.
    Locked_SI  = 1'b1;
    RstReq_RBI = '1;
    ClkEn_SI   = 1'b1;
    Delay_DI   = 16'd5;
    run_until_state(4, 1000);
    run(3);
    #2;
    mon_en  = 1'b0;
    Rst_RBI = 1'b0;
    #1;
    cmp("async_Rst_RBO",  t, 32'(Rst_RBO),  32'(0));
    cmp("async_ClkEn_SO", t, 32'(ClkEn_SO), 32'(0));
    cmp("async_Busy_SO",  t, 32'(Busy_SO),  32'(1));
    cmp("async_State_SO", t, 32'(State_SO), 32'(0));
    do_reset();
    run(40);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
